// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a simple in-order pipeline. Holds the program
// counter, issues word-aligned requests to instruction memory and captures the
// returned word into the IF/ID pipeline register. Handles downstream
// back-pressure (stall), control-flow redirects and a one-cycle boot state
// after reset.
//
// Parameters
//   RESET_PC     first fetch address after reset (low two bits forced to 0)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   imem_req     fetch request to instruction memory
//   imem_addr    word-aligned fetch address (the current PC)
//   imem_ready   imem_rdata carries the answer to this cycle's request
//   imem_rdata   fetched instruction word
//   stall        downstream cannot accept a new instruction this cycle
//   redirect     taken branch/jump; restart fetch at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] ignored
//   id_valid     IF/ID holds a real instruction
//   id_pc        PC of the instruction in IF/ID
//   id_instr     instruction in IF/ID (NOP when empty)
//   id_opcode    id_instr[6:0], feeds the control unit
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential next PC; the 32-bit add wraps naturally at the top of memory.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  localparam logic [31:0] RESET_PC_ALIGNED = align_word(RESET_PC);

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc_p0;      // address being fetched
  logic        vld_p1;     // IF/ID occupancy
  logic [31:0] pc_p1;
  logic [31:0] instr_p1;

  logic        blocked;    // IF/ID full and downstream not taking it
  logic        accept;     // capture imem_rdata into IF/ID this cycle

  assign blocked = vld_p1 && stall;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // A redirect always lands in FETCH so the target is requested next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FETCH;
    end else begin
      unique case (state)
        BOOT:    state_nxt = FETCH;
        FETCH:   state_nxt = blocked ? HOLD : FETCH;
        HOLD:    state_nxt = stall ? HOLD : FETCH;
        default: state_nxt = BOOT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // The request is dropped whenever IF/ID cannot take a new word, so memory
  // never returns data that would have to be thrown away for back-pressure.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    accept   = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req = !blocked;
        accept   = imem_ready && !redirect && !blocked;
      end
      default: begin
        imem_req = 1'b0;
        accept   = 1'b0;
      end
    endcase
    if (rst) begin
      imem_req = 1'b0;
      accept   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0 -> p1: PC update and IF/ID capture
  // Priority: reset, redirect, accept, then draining a consumed instruction.
  // When IF/ID is valid and stalled nothing below fires, so it holds.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC_ALIGNED;
      vld_p1   <= 1'b0;
      pc_p1    <= 32'h0000_0000;
      instr_p1 <= NOP;
    end else if (redirect) begin
      pc_p0    <= align_word(redirect_pc);
      vld_p1   <= 1'b0;
      instr_p1 <= NOP;
    end else if (accept) begin
      pc_p0    <= pc_incr(pc_p0);
      vld_p1   <= 1'b1;
      pc_p1    <= pc_p0;
      instr_p1 <= imem_rdata;
    end else if (vld_p1 && !stall) begin
      // Downstream consumed the word and nothing replaced it: insert a bubble.
      vld_p1   <= 1'b0;
      instr_p1 <= NOP;
    end
  end

  assign imem_addr = pc_p0;
  assign id_valid  = vld_p1;
  assign id_pc     = pc_p1;
  assign id_instr  = instr_p1;
  assign id_opcode = instr_p1[6:0];

`ifndef SYNTHESIS
  a_addr_aligned: assert property (@(posedge clk) imem_addr[1:0] == 2'b00);
  a_no_req_in_reset: assert property (@(posedge clk) rst |-> !imem_req);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;

  logic        ovr_en;
  logic [31:0] ovr_val;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: lw, sw, beq, add, then a distinct filler word.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_2083;  // lw  x1,0(x0)
      32'h0000_0004: return 32'h0011_2223;  // sw  x1,4(x2)
      32'h0000_0008: return 32'h0020_8463;  // beq x1,x2,8
      32'h0000_000C: return 32'h0020_81B3;  // add x3,x1,x2
      default:       return {a[24:0], 7'h13};
    endcase
  endfunction

  assign imem_rdata = ovr_en ? ovr_val : rom(imem_addr);
  assign w_rdata    = rom(w_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(w_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(w_valid),
    .id_pc(w_pc), .id_instr(w_instr), .id_opcode(w_opcode)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Hold reset two cycles, release; returns one cycle into BOOT.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; ovr_en = 1'b0; ovr_val = 32'h0;
    tick(); tick(); settle();
    n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", id_valid); else n_pass++;
    n_total++; if (id_pc !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", id_pc); else n_pass++;
    n_total++; if (id_instr !== 32'h0000_0013) $display("FAIL reset_instr: got %h want 00000013", id_instr); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", imem_addr); else n_pass++;
    // reset beats a simultaneous redirect and stall
    redirect = 1'b1; redirect_pc = 32'h0000_0200; stall = 1'b1;
    tick(); settle();
    n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_over_redirect: got %h want 00000000", imem_addr); else n_pass++;
    redirect = 1'b0; stall = 1'b0;
  endtask

  task automatic test_first_fetch();
    ovr_en = 1'b1; ovr_val = 32'h0000_0033;
    rst = 1'b0; settle();
    n_total++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %b want 0", imem_req); else n_pass++;
    tick(); settle();
    n_total++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL first_addr: got %h want 00000000", imem_addr); else n_pass++;
    tick(); settle();
    n_total++; if (id_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", id_valid); else n_pass++;
    n_total++; if (id_pc !== 32'h0) $display("FAIL first_pc: got %h want 00000000", id_pc); else n_pass++;
    n_total++; if (id_opcode !== 7'b0110011) $display("FAIL first_opcode: got %b want 0110011", id_opcode); else n_pass++;
    ovr_en = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc  [3];
    logic [31:0] exp_ins [3];
    logic [6:0]  exp_op  [3];
    exp_pc  = '{32'h0, 32'h4, 32'h8};
    exp_ins = '{32'h0000_2083, 32'h0011_2223, 32'h0020_8463};
    exp_op  = '{7'b0000011, 7'b0100011, 7'b1100011};
    do_reset();
    tick();  // BOOT -> FETCH at 0x0
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      n_total++; if (id_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, id_valid); else n_pass++;
      n_total++; if (id_pc !== exp_pc[i]) $display("FAIL stream_pc[%0d]: got %h want %h", i, id_pc, exp_pc[i]); else n_pass++;
      n_total++; if (id_opcode !== exp_op[i]) $display("FAIL stream_opcode[%0d]: got %b want %b", i, id_opcode, exp_op[i]); else n_pass++;
      n_total++; if (id_instr !== exp_ins[i]) $display("FAIL stream_instr[%0d]: got %h want %h", i, id_instr, exp_ins[i]); else n_pass++;
    end
  endtask

  // Continues from test_stream: IF/ID holds 0x8, PC is 0xC.
  task automatic test_stall();
    stall = 1'b1; settle();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); else n_pass++;
      n_total++; if (id_pc !== 32'h8) $display("FAIL stall_pc[%0d]: got %h want 00000008", i, id_pc); else n_pass++;
      n_total++; if (id_instr !== 32'h0020_8463) $display("FAIL stall_instr[%0d]: got %h want 00208463", i, id_instr); else n_pass++;
      n_total++; if (id_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, id_valid); else n_pass++;
      tick();
    end
    stall = 1'b0; settle();
    n_total++; if (imem_req !== 1'b0) $display("FAIL hold_exit_req: got %b want 0", imem_req); else n_pass++;
    tick(); settle();
    n_total++; if (id_valid !== 1'b0) $display("FAIL resume_bubble: got %b want 0", id_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL resume_req: got %b want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'hC) $display("FAIL resume_addr: got %h want 0000000c", imem_addr); else n_pass++;
    tick(); settle();
    n_total++; if (id_pc !== 32'hC || id_valid !== 1'b1) $display("FAIL resume_pc: got %h/%b want 0000000c/1", id_pc, id_valid); else n_pass++;
    n_total++; if (id_instr !== 32'h0020_81B3) $display("FAIL resume_instr: got %h want 002081b3", id_instr); else n_pass++;
  endtask

  // Continues: IF/ID holds 0xC, PC is 0x10.
  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    tick();
    redirect = 1'b0; ovr_en = 1'b0; settle();
    n_total++; if (id_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", id_valid); else n_pass++;
    n_total++; if (id_opcode !== 7'b0010011) $display("FAIL redir_opcode: got %b want 0010011", id_opcode); else n_pass++;
    n_total++; if (id_instr !== 32'h0000_0013) $display("FAIL redir_instr: got %h want 00000013", id_instr); else n_pass++;
    n_total++; if (imem_addr !== 32'h100) $display("FAIL redir_addr: got %h want 00000100", imem_addr); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL redir_req: got %b want 1", imem_req); else n_pass++;
    tick(); settle();
    n_total++; if (id_pc !== 32'h100 || id_valid !== 1'b1) $display("FAIL redir_target_pc: got %h/%b want 00000100/1", id_pc, id_valid); else n_pass++;
    n_total++; if (id_instr !== 32'h0000_8013) $display("FAIL redir_target_instr: got %h want 00008013", id_instr); else n_pass++;
    // redirect while stalled in HOLD
    stall = 1'b1; tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0; stall = 1'b0; settle();
    n_total++; if (id_valid !== 1'b0) $display("FAIL redir_hold_valid: got %b want 0", id_valid); else n_pass++;
    n_total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) $display("FAIL redir_hold_addr: got %h/%b want 00000040/1", imem_addr, imem_req); else n_pass++;
    tick(); settle();
    n_total++; if (id_pc !== 32'h40 || id_instr !== 32'h0000_2013) $display("FAIL redir_hold_fetch: got %h/%h want 00000040/00002013", id_pc, id_instr); else n_pass++;
  endtask

  // Continues: IF/ID holds 0x40, PC is 0x44.
  task automatic test_ready_low();
    imem_ready = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      n_total++; if (imem_req !== 1'b1) $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); else n_pass++;
      n_total++; if (imem_addr !== 32'h44) $display("FAIL wait_addr[%0d]: got %h want 00000044", i, imem_addr); else n_pass++;
      n_total++; if (id_valid !== 1'b0) $display("FAIL wait_valid[%0d]: got %b want 0", i, id_valid); else n_pass++;
    end
    imem_ready = 1'b1;
    tick(); settle();
    n_total++; if (id_pc !== 32'h44 || id_valid !== 1'b1) $display("FAIL wait_done: got %h/%b want 00000044/1", id_pc, id_valid); else n_pass++;
  endtask

  // Continues: state FETCH with PC 0x48.
  task automatic test_reset_mid_fetch();
    rst = 1'b1; ovr_en = 1'b1; ovr_val = 32'hBAD0_0033;
    tick(); settle();
    n_total++; if (id_valid !== 1'b0 || id_instr !== 32'h0000_0013) $display("FAIL midrst_id: got %b/%h want 0/00000013", id_valid, id_instr); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL midrst_req: got %b want 0", imem_req); else n_pass++;
    rst = 1'b0; ovr_en = 1'b0;
    tick(); settle();
    n_total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) $display("FAIL midrst_restart: got %h/%b want 00000000/1", imem_addr, imem_req); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    tick(); settle();
    n_total++; if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b1) $display("FAIL wrap_first: got %h/%b want fffffffc/1", w_addr, w_req); else n_pass++;
    tick(); settle();
    n_total++; if (w_addr !== 32'h0) $display("FAIL wrap_second: got %h want 00000000", w_addr); else n_pass++;
    n_total++; if (w_pc !== 32'hFFFF_FFFC || w_instr !== 32'hFFFF_FE13) $display("FAIL wrap_id: got %h/%h want fffffffc/fffffe13", w_pc, w_instr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_low();
    test_reset_mid_fetch();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
